sseg_arbiter: RTL and testbench

SSEG_ARBITER -- requirements
Module: sseg_arbiter

---
 rtl/sseg_arbiter.sv | 120 ++++++++++++
 tb/tb_sseg_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_arbiter.sv
// Two-requester arbiter owning a 4-digit seven-segment display.
// Winner holds the display for HOLD_CYCLES; output may blink.
module sseg_arbiter #(
   parameter int HOLD_CYCLES  = 100_000_000,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        req_a,
   input  logic [15:0] data_a,
   input  logic        req_b,
   input  logic [15:0] data_b,
   input  logic        blink_en,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [15:0] display_data,
   output logic        owner,
   output logic        busy
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      HOLD
   } state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [15:0]   shadow;

   logic          pick_b;
   logic          own_req;
   logic [15:0]   cap_data;
   logic [15:0]   disp_src;

   // Ties go to the requester that is not the last owner.
   always_comb begin
      pick_b   = req_b && (!req_a || !owner);
      own_req  = owner ? req_b : req_a;
      cap_data = owner ? data_b : data_a;
      disp_src = (state == GRANT) ? cap_data : shadow;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= IDLE;
         gnt_a    <= 1'b0;
         gnt_b    <= 1'b0;
         busy     <= 1'b0;
         owner    <= 1'b1;
         shadow   <= 16'hFFFF;
         hold_cnt <= '0;
      end else begin
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  state <= GRANT;
                  owner <= pick_b;
                  gnt_a <= !pick_b;
                  gnt_b <= pick_b;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               shadow   <= cap_data;
               hold_cnt <= '0;
               state    <= HOLD;
               busy     <= 1'b1;
            end
            HOLD: begin
               if (own_req) begin
                  state <= GRANT;
                  gnt_a <= !owner;
                  gnt_b <= owner;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Blink runs free of the FSM; disabling it parks on the visible phase.
   always_ff @(posedge clk) begin
      if (clear) begin
         blink_cnt    <= '0;
         phase        <= 1'b0;
         display_data <= 16'hFFFF;
      end else begin
         if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= !phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         display_data <= (blink_en && phase) ? 16'hFFFF : disp_src;
      end
   end

endmodule

// File: tb/tb_sseg_arbiter.sv
// Scoreboard bench for sseg_arbiter with HOLD_CYCLES=4, BLINK_CYCLES=3.
// Expected per-cycle outputs are queued up front, observed ones recorded.
module tb_sseg_arbiter;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        req_a = 1'b0;
   logic [15:0] data_a = 16'h0000;
   logic        req_b = 1'b0;
   logic [15:0] data_b = 16'h0000;
   logic        blink_en = 1'b0;
   logic        gnt_a;
   logic        gnt_b;
   logic [15:0] display_data;
   logic        owner;
   logic        busy;

   typedef struct packed {
      logic        ga;
      logic        gb;
      logic        bsy;
      logic        own;
      logic [15:0] disp;
   } obs_t;

   obs_t expq[$];
   obs_t actq[$];
   int   checks = 0;
   int   errors = 0;

   sseg_arbiter #(
      .HOLD_CYCLES (4),
      .BLINK_CYCLES(3)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .req_a       (req_a),
      .data_a      (data_a),
      .req_b       (req_b),
      .data_b      (data_b),
      .blink_en    (blink_en),
      .gnt_a       (gnt_a),
      .gnt_b       (gnt_b),
      .display_data(display_data),
      .owner       (owner),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void push(input logic ga, input logic gb,
                                input logic bsy, input logic own,
                                input logic [15:0] disp);
      obs_t e;
      e.ga   = ga;
      e.gb   = gb;
      e.bsy  = bsy;
      e.own  = own;
      e.disp = disp;
      expq.push_back(e);
   endfunction

   // Advance n edges, record outputs; requesters drop req on their grant.
   task automatic tick(input int n);
      obs_t a;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         a.ga   = gnt_a;
         a.gb   = gnt_b;
         a.bsy  = busy;
         a.own  = owner;
         a.disp = display_data;
         actq.push_back(a);
         if (gnt_a) req_a = 1'b0;
         if (gnt_b) req_b = 1'b0;
      end
   endtask

   task automatic do_clear();
      req_a    = 1'b0;
      req_b    = 1'b0;
      blink_en = 1'b0;
      clear    = 1'b1;
      push(0, 0, 0, 1, 16'hFFFF);
      tick(1);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, a;
      actq.delete();
      expq.delete();
      clear  = 1'b1;
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 16'h1111;
      data_b = 16'h2222;
      for (int i = 0; i < 3; i++) push(0, 0, 0, 1, 16'hFFFF);
      tick(3);
      clear = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL reset: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL reset: got %h required %h", a, e);
            end
         end
      end
   endtask

   task automatic test_single();
      obs_t e, a;
      actq.delete();
      expq.delete();
      do_clear();
      req_a  = 1'b1;
      data_a = 16'h1234;
      push(1, 0, 1, 0, 16'hFFFF);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 0, 16'h1234);
      push(0, 0, 0, 0, 16'h1234);
      push(0, 0, 0, 0, 16'h1234);
      tick(7);
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL single: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL single: got %h required %h", a, e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, a;
      actq.delete();
      expq.delete();
      do_clear();
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 16'hAAAA;
      data_b = 16'hBBBB;
      push(1, 0, 1, 0, 16'hFFFF);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 0, 16'hAAAA);
      push(0, 0, 0, 0, 16'hAAAA);
      push(0, 1, 1, 1, 16'hAAAA);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 1, 16'hBBBB);
      push(0, 0, 0, 1, 16'hBBBB);
      tick(12);
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 16'h1111;
      data_b = 16'h2222;
      push(1, 0, 1, 0, 16'hBBBB);
      push(0, 0, 1, 0, 16'h1111);
      tick(2);
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL back_to_back: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL back_to_back: got %h required %h", a, e);
            end
         end
      end
   endtask

   task automatic test_overwrite();
      obs_t e, a;
      actq.delete();
      expq.delete();
      do_clear();
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 16'h1234;
      data_b = 16'hBBBB;
      push(1, 0, 1, 0, 16'hFFFF);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 0, 16'h1234);
      tick(5);
      req_a  = 1'b1;
      data_a = 16'hC0E0;
      push(1, 0, 1, 0, 16'h1234);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 0, 16'hC0E0);
      push(0, 0, 0, 0, 16'hC0E0);
      push(0, 1, 1, 1, 16'hC0E0);
      push(0, 0, 1, 1, 16'hBBBB);
      tick(8);
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL overwrite: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL overwrite: got %h required %h", a, e);
            end
         end
      end
   endtask

   task automatic test_blink();
      obs_t e, a;
      actq.delete();
      expq.delete();
      do_clear();
      req_a  = 1'b1;
      data_a = 16'h5678;
      push(1, 0, 1, 0, 16'hFFFF);
      for (int i = 0; i < 4; i++) push(0, 0, 1, 0, 16'h5678);
      push(0, 0, 0, 0, 16'h5678);
      tick(6);
      blink_en = 1'b1;
      for (int i = 0; i < 10; i++)
         push(0, 0, 0, 0, ((i / 3) % 2 == 1) ? 16'hFFFF : 16'h5678);
      tick(10);
      blink_en = 1'b0;
      push(0, 0, 0, 0, 16'h5678);
      push(0, 0, 0, 0, 16'h5678);
      tick(2);
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL blink: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL blink: got %h required %h", a, e);
            end
         end
      end
   endtask

   task automatic test_clear_grant();
      obs_t e, a;
      actq.delete();
      expq.delete();
      do_clear();
      req_a  = 1'b1;
      data_a = 16'h4321;
      push(1, 0, 1, 0, 16'hFFFF);
      tick(1);
      clear = 1'b1;
      push(0, 0, 0, 1, 16'hFFFF);
      tick(1);
      clear = 1'b0;
      push(0, 0, 0, 1, 16'hFFFF);
      push(0, 0, 0, 1, 16'hFFFF);
      tick(2);
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (actq.size() == 0) begin
            errors++;
            $display("FAIL clear_grant: no output, required %h", e);
         end else begin
            a = actq.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL clear_grant: got %h required %h", a, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overwrite();
      test_blink();
      test_clear_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
